// File: rtl/pad_tile_buf.sv
`default_nettype none
// ============================================================================
// Module   : pad_tile_buf
// Purpose  : Tile buffer between the pooling array and the line-buffer/GLB
//            writer. Captures one unpadded tile (LANES channels per pixel),
//            then streams the padded tile row-major with backpressure. Pad
//            pixels are generated on the fly, so the memory is never cleared.
// Ports    : clock, rst_n           clock / async active-low reset
//            cfg_*                  tile geometry, per-side pad, pad value
//            abort                  synchronous return to IDLE
//            in_valid/in_ready/in_data      input stream (FILL)
//            out_valid/out_ready/out_data/out_last   output stream (DUMP)
//            out_length/out_height  padded tile dimensions
//            busy, fill_done, dump_done, cfg_err     status
// Revision : 1.0 - initial release
// ============================================================================
module pad_tile_buf #(
  parameter int LANES    = 8,
  parameter int DATA_WID = 16,
  parameter int MAX_DIM  = 32,
  parameter int DIM_WID  = 6,
  parameter int PAD_WID  = 3
) (
  input  logic                        clock,
  input  logic                        rst_n,
  input  logic                        cfg_start,
  input  logic [DIM_WID-1:0]          cfg_length,
  input  logic [DIM_WID-1:0]          cfg_height,
  input  logic [PAD_WID-1:0]          cfg_pad_top,
  input  logic [PAD_WID-1:0]          cfg_pad_bottom,
  input  logic [PAD_WID-1:0]          cfg_pad_left,
  input  logic [PAD_WID-1:0]          cfg_pad_right,
  input  logic [DATA_WID-1:0]         cfg_pad_value,
  input  logic                        abort,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*DATA_WID-1:0]   in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*DATA_WID-1:0]   out_data,
  output logic                        out_last,
  output logic [DIM_WID:0]            out_length,
  output logic [DIM_WID:0]            out_height,
  output logic                        busy,
  output logic                        fill_done,
  output logic                        dump_done,
  output logic                        cfg_err
);

  localparam int c_DW    = LANES * DATA_WID;
  localparam int c_DEPTH = MAX_DIM * MAX_DIM;
  localparam int c_AW    = $clog2(c_DEPTH);
  localparam int c_PW    = DIM_WID + 1;          // padded-dimension width
  localparam int c_EXT   = c_PW - PAD_WID;

  localparam logic [c_PW-1:0]    c_MAX_DIM = c_PW'(MAX_DIM);
  localparam logic [c_PW-1:0]    c_ONE_P   = c_PW'(1);
  localparam logic [DIM_WID-1:0] c_ONE_D   = DIM_WID'(1);
  localparam logic [c_AW-1:0]    c_ONE_A   = c_AW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DUMP = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Latched configuration
  logic [DIM_WID-1:0]  r_length;
  logic [DIM_WID-1:0]  r_height;
  logic [PAD_WID-1:0]  r_pad_top;
  logic [PAD_WID-1:0]  r_pad_bottom;
  logic [PAD_WID-1:0]  r_pad_left;
  logic [PAD_WID-1:0]  r_pad_right;
  logic [DATA_WID-1:0] r_pad_value;

  // Fill side
  logic [c_AW-1:0]     r_wr_addr;
  logic [DIM_WID-1:0]  r_wr_col;
  logic [DIM_WID-1:0]  r_wr_row;

  // Dump side
  logic [c_PW-1:0]     r_row;
  logic [c_PW-1:0]     r_col;
  logic [c_AW-1:0]     r_rd_ptr;
  logic                r_gen_done;
  logic                r_out_valid;
  logic                r_is_pad;
  logic                r_last;
  logic [c_DW-1:0]     r_mem_q;
  logic [c_PW-1:0]     r_out_length;
  logic [c_PW-1:0]     r_out_height;

  logic                r_fill_done;
  logic                r_dump_done;
  logic                r_cfg_err;

  logic [c_DW-1:0]     r_mem [0:c_DEPTH-1];

  logic                w_cfg_ok;
  logic                w_in_hs;
  logic                w_out_hs;
  logic                w_fill_last;
  logic                w_issue;
  logic                w_interior;
  logic                w_col_last;
  logic                w_gen_last;
  logic [c_PW-1:0]     w_top_x;
  logic [c_PW-1:0]     w_left_x;
  logic [c_PW-1:0]     w_len_x;
  logic [c_PW-1:0]     w_hgt_x;
  logic [c_PW-1:0]     w_pad_len;
  logic [c_PW-1:0]     w_pad_hgt;
  logic [c_DW-1:0]     w_pad_word;

  assign w_cfg_ok = (cfg_length != '0) && (cfg_height != '0) &&
                    ({1'b0, cfg_length} <= c_MAX_DIM) &&
                    ({1'b0, cfg_height} <= c_MAX_DIM);

  assign w_top_x   = {{c_EXT{1'b0}}, r_pad_top};
  assign w_left_x  = {{c_EXT{1'b0}}, r_pad_left};
  assign w_len_x   = {1'b0, r_length};
  assign w_hgt_x   = {1'b0, r_height};
  assign w_pad_len = w_len_x + w_left_x + {{c_EXT{1'b0}}, r_pad_right};
  assign w_pad_hgt = w_hgt_x + w_top_x + {{c_EXT{1'b0}}, r_pad_bottom};

  assign w_in_hs     = in_valid && in_ready;
  assign w_out_hs    = r_out_valid && out_ready;
  assign w_fill_last = (r_wr_col == r_length - c_ONE_D) &&
                       (r_wr_row == r_height - c_ONE_D);

  // A new grid position is issued whenever the output register is empty or
  // is being drained this cycle; this gives one beat per cycle under full
  // throughput and freezes everything while the consumer stalls.
  assign w_issue    = (r_state == S_DUMP) && !r_gen_done && !abort &&
                      (!r_out_valid || out_ready);
  assign w_interior = (r_row >= w_top_x) && (r_row < w_top_x + w_hgt_x) &&
                      (r_col >= w_left_x) && (r_col < w_left_x + w_len_x);
  assign w_col_last = (r_col == r_out_length - c_ONE_P);
  assign w_gen_last = w_col_last && (r_row == r_out_height - c_ONE_P);

  assign w_pad_word = {LANES{r_pad_value}};

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    busy        = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (cfg_start && w_cfg_ok) begin
          w_state_nxt = S_FILL;
        end
      end
      S_FILL: begin
        in_ready = 1'b1;
        if (in_valid && w_fill_last) begin
          w_state_nxt = S_DUMP;
        end
      end
      S_DUMP: begin
        if (w_out_hs && r_last) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (abort) begin
      w_state_nxt = S_IDLE;
    end
  end

  // ----------------------------------------------------------- datapath
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_length     <= '0;
      r_height     <= '0;
      r_pad_top    <= '0;
      r_pad_bottom <= '0;
      r_pad_left   <= '0;
      r_pad_right  <= '0;
      r_pad_value  <= '0;
      r_wr_addr    <= '0;
      r_wr_col     <= '0;
      r_wr_row     <= '0;
      r_row        <= '0;
      r_col        <= '0;
      r_rd_ptr     <= '0;
      r_gen_done   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_is_pad     <= 1'b0;
      r_last       <= 1'b0;
      r_out_length <= '0;
      r_out_height <= '0;
      r_fill_done  <= 1'b0;
      r_dump_done  <= 1'b0;
      r_cfg_err    <= 1'b0;
    end else begin
      r_fill_done <= 1'b0;
      r_dump_done <= 1'b0;
      r_cfg_err   <= 1'b0;
      if (abort) begin
        r_out_valid <= 1'b0;
      end else begin
        if (r_state == S_IDLE && cfg_start) begin
          if (w_cfg_ok) begin
            r_length     <= cfg_length;
            r_height     <= cfg_height;
            r_pad_top    <= cfg_pad_top;
            r_pad_bottom <= cfg_pad_bottom;
            r_pad_left   <= cfg_pad_left;
            r_pad_right  <= cfg_pad_right;
            r_pad_value  <= cfg_pad_value;
            r_wr_addr    <= '0;
            r_wr_col     <= '0;
            r_wr_row     <= '0;
            r_row        <= '0;
            r_col        <= '0;
            r_rd_ptr     <= '0;
            r_gen_done   <= 1'b0;
          end else begin
            r_cfg_err <= 1'b1;
          end
        end

        // Row/column tracking replaces a length*height product.
        if (w_in_hs) begin
          r_wr_addr <= r_wr_addr + c_ONE_A;
          if (r_wr_col == r_length - c_ONE_D) begin
            r_wr_col <= '0;
            r_wr_row <= r_wr_row + c_ONE_D;
          end else begin
            r_wr_col <= r_wr_col + c_ONE_D;
          end
          if (w_fill_last) begin
            r_fill_done  <= 1'b1;
            r_out_length <= w_pad_len;
            r_out_height <= w_pad_hgt;
          end
        end

        if (w_issue) begin
          r_out_valid <= 1'b1;
          r_is_pad    <= !w_interior;
          r_last      <= w_gen_last;
          if (w_interior) begin
            r_rd_ptr <= r_rd_ptr + c_ONE_A;
          end
          if (w_gen_last) begin
            r_gen_done <= 1'b1;
          end
          if (w_col_last) begin
            r_col <= '0;
            r_row <= r_row + c_ONE_P;
          end else begin
            r_col <= r_col + c_ONE_P;
          end
        end else if (w_out_hs) begin
          r_out_valid <= 1'b0;
        end

        if (w_out_hs && r_last) begin
          r_dump_done <= 1'b1;
        end
      end
    end
  end

  // Storage: no reset so it maps onto block RAM. The read register only
  // loads on an interior issue, so it holds its word through a stall.
  always_ff @(posedge clock) begin
    if (w_in_hs) begin
      r_mem[r_wr_addr] <= in_data;
    end
    if (w_issue && w_interior) begin
      r_mem_q <= r_mem[r_rd_ptr];
    end
  end

  // Outputs are masked by out_valid so they read zero out of reset even
  // though the RAM read register itself is not reset.
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_valid ? (r_is_pad ? w_pad_word : r_mem_q) : '0;
  assign out_last   = r_out_valid && r_last;
  assign out_length = r_out_length;
  assign out_height = r_out_height;
  assign fill_done  = r_fill_done;
  assign dump_done  = r_dump_done;
  assign cfg_err    = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_pad_tile_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_pad_tile_buf
// Purpose  : Directed self-checking bench for pad_tile_buf.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pad_tile_buf;

  localparam int LANES    = 8;
  localparam int DATA_WID = 16;
  localparam int MAX_DIM  = 32;
  localparam int DIM_WID  = 6;
  localparam int PAD_WID  = 3;
  localparam int DW       = LANES * DATA_WID;
  localparam logic [15:0] PADV = 16'h7FFF;

  logic                clock = 1'b0;
  logic                rst_n = 1'b0;
  logic                cfg_start = 1'b0;
  logic [DIM_WID-1:0]  cfg_length = '0;
  logic [DIM_WID-1:0]  cfg_height = '0;
  logic [PAD_WID-1:0]  cfg_pad_top = '0;
  logic [PAD_WID-1:0]  cfg_pad_bottom = '0;
  logic [PAD_WID-1:0]  cfg_pad_left = '0;
  logic [PAD_WID-1:0]  cfg_pad_right = '0;
  logic [DATA_WID-1:0] cfg_pad_value = PADV;
  logic                abort = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [DW-1:0]       in_data = '0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [DW-1:0]       out_data;
  logic                out_last;
  logic [DIM_WID:0]    out_length;
  logic [DIM_WID:0]    out_height;
  logic                busy;
  logic                fill_done;
  logic                dump_done;
  logic                cfg_err;

  pad_tile_buf #(
    .LANES(LANES), .DATA_WID(DATA_WID), .MAX_DIM(MAX_DIM),
    .DIM_WID(DIM_WID), .PAD_WID(PAD_WID)
  ) dut (
    .clock(clock), .rst_n(rst_n), .cfg_start(cfg_start),
    .cfg_length(cfg_length), .cfg_height(cfg_height),
    .cfg_pad_top(cfg_pad_top), .cfg_pad_bottom(cfg_pad_bottom),
    .cfg_pad_left(cfg_pad_left), .cfg_pad_right(cfg_pad_right),
    .cfg_pad_value(cfg_pad_value), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_length(out_length), .out_height(out_height),
    .busy(busy), .fill_done(fill_done), .dump_done(dump_done),
    .cfg_err(cfg_err)
  );

  always #5 clock = ~clock;

  int n_assert = 0;
  int n_fail   = 0;
  int cur_l, cur_h, cur_t, cur_lf;
  logic [15:0] cap [0:2115];

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Geometry model: expected lane word for padded beat idx.
  function automatic logic [15:0] exp_pix(input int idx, input int ol);
    int r, c;
    r = idx / ol;
    c = idx % ol;
    if (r >= cur_t && r < cur_t + cur_h && c >= cur_lf && c < cur_lf + cur_l)
      return 16'((r - cur_t) * cur_l + (c - cur_lf));
    return PADV;
  endfunction

  task automatic start_cfg(input int l, input int h, input int t, input int b,
                           input int lf, input int r);
    cfg_length     = DIM_WID'(l);
    cfg_height     = DIM_WID'(h);
    cfg_pad_top    = PAD_WID'(t);
    cfg_pad_bottom = PAD_WID'(b);
    cfg_pad_left   = PAD_WID'(lf);
    cfg_pad_right  = PAD_WID'(r);
    cfg_start      = 1'b1;
    tick();
    cfg_start      = 1'b0;
  endtask

  task automatic fill(input int k0, input int k1);
    for (int k = k0; k < k1; k++) begin
      int guard;
      guard    = 0;
      in_valid = 1'b1;
      in_data  = {LANES{16'(k)}};
      while (!in_ready && guard < 10) begin
        tick();
        guard++;
      end
      if (!in_ready) begin
        chk("fill_ready_timeout", DW'(in_ready), DW'(1));
        break;
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  // Fill the remainder of a tile and check the fill_done pulse and the
  // two-cycle latency to the first output beat.
  task automatic fill_and_first(input int k0, input int n);
    fill(k0, n);
    chk("fill_done_pulse", DW'(fill_done), DW'(1));
    chk("in_ready_drop",   DW'(in_ready),  DW'(0));
    chk("valid_not_early", DW'(out_valid), DW'(0));
    tick();
    chk("fill_done_once",  DW'(fill_done), DW'(0));
    chk("first_valid",     DW'(out_valid), DW'(1));
  endtask

  task automatic run_dump(input int n, input int ol, input bit stall, input string tag);
    int beats, cyc;
    logic pv, pr, plast;
    logic [DW-1:0] pd;
    beats = 0; cyc = 0; pv = 1'b0; pr = 1'b0; plast = 1'b0; pd = '0;
    while (beats < n && cyc < n * 4 + 100) begin
      out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pv && !pr) begin
        chk({tag, "_hold_valid"}, DW'(out_valid), DW'(1));
        chk({tag, "_hold_data"},  out_data, pd);
        chk({tag, "_hold_last"},  DW'(out_last), DW'(plast));
      end
      if (out_valid && out_ready) begin
        cap[beats] = out_data[15:0];
        chk({tag, "_data"}, out_data, {LANES{exp_pix(beats, ol)}});
        chk({tag, "_last"}, DW'(out_last), DW'(beats == n - 1));
        beats++;
      end
      pv = out_valid; pr = out_ready; pd = out_data; plast = out_last;
      tick();
      cyc++;
    end
    out_ready = 1'b1;
    chk({tag, "_beat_count"}, DW'(beats), DW'(n));
    chk({tag, "_dump_done"},  DW'(dump_done), DW'(1));
    chk({tag, "_busy_low"},   DW'(busy), DW'(0));
    chk({tag, "_valid_low"},  DW'(out_valid), DW'(0));
  endtask

  initial begin
    // ---------------- reset state
    repeat (3) @(posedge clock);
    #1;
    chk("rst_in_ready",   DW'(in_ready),   DW'(0));
    chk("rst_out_valid",  DW'(out_valid),  DW'(0));
    chk("rst_out_data",   out_data,        '0);
    chk("rst_out_last",   DW'(out_last),   DW'(0));
    chk("rst_out_length", DW'(out_length), DW'(0));
    chk("rst_out_height", DW'(out_height), DW'(0));
    chk("rst_busy",       DW'(busy),       DW'(0));
    chk("rst_fill_done",  DW'(fill_done),  DW'(0));
    chk("rst_dump_done",  DW'(dump_done),  DW'(0));
    chk("rst_cfg_err",    DW'(cfg_err),    DW'(0));
    #2 rst_n = 1'b1;
    tick();

    // ---------------- 1: full pad, no stall
    out_ready = 1'b1;
    cur_l = 3; cur_h = 2; cur_t = 1; cur_lf = 1;
    start_cfg(3, 2, 1, 1, 1, 1);
    chk("t1_busy_rise", DW'(busy), DW'(1));
    chk("t1_in_ready",  DW'(in_ready), DW'(1));
    fill_and_first(0, 6);
    chk("t1_out_length", DW'(out_length), DW'(5));
    chk("t1_out_height", DW'(out_height), DW'(4));
    run_dump(20, 5, 1'b0, "t1");
    chk("t1_beat0",  DW'(cap[0]),  DW'(PADV));
    chk("t1_beat6",  DW'(cap[6]),  DW'(0));
    chk("t1_beat7",  DW'(cap[7]),  DW'(1));
    chk("t1_beat13", DW'(cap[13]), DW'(5));
    chk("t1_beat19", DW'(cap[19]), DW'(PADV));

    // ---------------- 2: asymmetric pad, started on the dump_done cycle
    cur_l = 2; cur_h = 2; cur_t = 0; cur_lf = 3;
    start_cfg(2, 2, 0, 2, 3, 0);
    chk("t2_start_on_done", DW'(busy), DW'(1));
    chk("t2_dump_done_once", DW'(dump_done), DW'(0));
    fill_and_first(0, 4);
    chk("t2_out_length", DW'(out_length), DW'(5));
    chk("t2_out_height", DW'(out_height), DW'(4));
    run_dump(20, 5, 1'b0, "t2");
    chk("t2_r0c0", DW'(cap[0]),  DW'(PADV));
    chk("t2_r0c2", DW'(cap[2]),  DW'(PADV));
    chk("t2_r0c3", DW'(cap[3]),  DW'(0));
    chk("t2_r0c4", DW'(cap[4]),  DW'(1));
    chk("t2_r1c4", DW'(cap[9]),  DW'(3));
    chk("t2_r2c0", DW'(cap[10]), DW'(PADV));
    chk("t2_r3c4", DW'(cap[19]), DW'(PADV));

    // ---------------- 3: random backpressure
    cur_l = 3; cur_h = 2; cur_t = 1; cur_lf = 1;
    start_cfg(3, 2, 1, 1, 1, 1);
    fill_and_first(0, 6);
    run_dump(20, 5, 1'b1, "t3");
    chk("t3_beat6",  DW'(cap[6]),  DW'(0));
    chk("t3_beat13", DW'(cap[13]), DW'(5));

    // ---------------- 4: max tile
    cur_l = 32; cur_h = 32; cur_t = 7; cur_lf = 7;
    start_cfg(32, 32, 7, 7, 7, 7);
    fill_and_first(0, 1024);
    chk("t4_out_length", DW'(out_length), DW'(46));
    chk("t4_out_height", DW'(out_height), DW'(46));
    run_dump(2116, 46, 1'b0, "t4");
    chk("t4_first_pix", DW'(cap[329]),  DW'(0));
    chk("t4_last_pix",  DW'(cap[1786]), DW'(1023));
    chk("t4_last_beat", DW'(cap[2115]), DW'(PADV));

    // ---------------- 5: config errors and ignored start
    start_cfg(0, 2, 1, 1, 1, 1);
    chk("t5_len0_err",  DW'(cfg_err), DW'(1));
    chk("t5_len0_busy", DW'(busy),    DW'(0));
    tick();
    chk("t5_err_pulse", DW'(cfg_err), DW'(0));
    start_cfg(3, 33, 1, 1, 1, 1);
    chk("t5_h33_err",  DW'(cfg_err), DW'(1));
    chk("t5_h33_busy", DW'(busy),    DW'(0));
    tick();
    cur_l = 3; cur_h = 2; cur_t = 0; cur_lf = 0;
    start_cfg(3, 2, 0, 0, 0, 0);
    fill(0, 2);
    start_cfg(1, 1, 2, 2, 2, 2);
    chk("t5_ign_busy",  DW'(busy),     DW'(1));
    chk("t5_ign_ready", DW'(in_ready), DW'(1));
    chk("t5_ign_err",   DW'(cfg_err),  DW'(0));
    fill_and_first(2, 6);
    chk("t5_out_length", DW'(out_length), DW'(3));
    chk("t5_out_height", DW'(out_height), DW'(2));
    run_dump(6, 3, 1'b0, "t5");

    // ---------------- 6: abort during FILL, then a clean tile
    cur_l = 3; cur_h = 2; cur_t = 1; cur_lf = 1;
    start_cfg(3, 2, 1, 1, 1, 1);
    fill(0, 3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t6_abort_ready", DW'(in_ready),  DW'(0));
    chk("t6_abort_busy",  DW'(busy),      DW'(0));
    chk("t6_abort_fd",    DW'(fill_done), DW'(0));
    tick();
    chk("t6_abort_fd2",   DW'(fill_done), DW'(0));
    start_cfg(3, 2, 1, 1, 1, 1);
    fill_and_first(0, 6);
    run_dump(20, 5, 1'b0, "t6");

    // ---------------- 6b: asynchronous reset during DUMP
    start_cfg(3, 2, 1, 1, 1, 1);
    fill_and_first(0, 6);
    out_ready = 1'b0;
    tick();
    chk("t6r_stall_valid", DW'(out_valid), DW'(1));
    chk("t6r_stall_data",  out_data, {LANES{PADV}});
    #2 rst_n = 1'b0;
    #1;
    chk("t6r_out_valid",  DW'(out_valid),  DW'(0));
    chk("t6r_out_data",   out_data,        '0);
    chk("t6r_out_last",   DW'(out_last),   DW'(0));
    chk("t6r_out_length", DW'(out_length), DW'(0));
    chk("t6r_out_height", DW'(out_height), DW'(0));
    chk("t6r_busy",       DW'(busy),       DW'(0));
    chk("t6r_in_ready",   DW'(in_ready),   DW'(0));
    chk("t6r_dump_done",  DW'(dump_done),  DW'(0));
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("t6r_idle_after", DW'(busy), DW'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
